freq_div_ctrl: RTL and testbench

//   Runtime-programmable divide-by-N controller for the clock-divider datapath.

---
 rtl/freq_div_ctrl.sv | 97 +++++++++
 tb/tb_freq_div_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/freq_div_ctrl.sv
// rtl/freq_div_ctrl.sv - runtime-programmable divide-by-N controller with boundary-aligned divisor updates
module freq_div_ctrl #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_valid,
  output logic             div_ready,
  output logic             div_err,
  output logic             div_out,
  output logic             tick,
  output logic [WIDTH-1:0] cur_div,
  output logic             busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_PEND = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_cur_div;
  logic [WIDTH-1:0] r_pending;
  logic             r_ready;
  logic             r_err;
  logic             w_xfer;
  logic             w_bad;
  logic             w_good;
  logic             w_boundary;
  logic [WIDTH:0]   w_half;

  assign w_xfer     = div_valid & r_ready;
  assign w_bad      = w_xfer & (div_in < WIDTH'(2));
  assign w_good     = w_xfer & ~w_bad;
  assign w_boundary = (r_state != ST_IDLE) && (r_count == r_cur_div - WIDTH'(1));
  // One extra bit so (N+1)>>1 stays correct for the largest divisor.
  assign w_half     = ({1'b0, r_cur_div} + (WIDTH+1)'(1)) >> 1;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (en) w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (w_boundary && !en) w_state_nxt = ST_IDLE;
        else if (w_good)       w_state_nxt = ST_PEND;
      end
      ST_PEND: if (w_boundary) w_state_nxt = en ? ST_RUN : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_count   <= '0;
      r_cur_div <= WIDTH'(DEFAULT_DIV);
      r_pending <= '0;
      r_ready   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt != ST_PEND);
      r_err   <= w_bad;
      case (r_state)
        ST_IDLE: begin
          r_count <= '0;
          if (w_good) r_cur_div <= div_in;
        end
        ST_RUN: begin
          r_count <= w_boundary ? '0 : r_count + WIDTH'(1);
          // A transfer landing on a stopping boundary goes straight to cur_div, as IDLE would.
          if (w_good) begin
            if (w_boundary && !en) r_cur_div <= div_in;
            else                   r_pending <= div_in;
          end
        end
        ST_PEND: begin
          r_count <= w_boundary ? '0 : r_count + WIDTH'(1);
          if (w_boundary) r_cur_div <= r_pending;
        end
        default: r_count <= '0;
      endcase
    end
  end

  assign div_ready = r_ready;
  assign div_err   = r_err;
  assign cur_div   = r_cur_div;
  assign busy      = (r_state != ST_IDLE);
  assign tick      = busy && (r_count == '0);
  assign div_out   = busy && ({1'b0, r_count} < w_half);

endmodule

// File: tb/tb_freq_div_ctrl.sv
// tb/tb_freq_div_ctrl.sv - scoreboard bench for freq_div_ctrl with directed vectors
module tb_freq_div_ctrl;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] div_in;
  logic       div_valid;
  logic       div_ready;
  logic       div_err;
  logic       div_out;
  logic       tick;
  logic [7:0] cur_div;
  logic       busy;

  typedef struct {
    int         tid;
    logic       dout;
    logic       tick;
    logic       busy;
    logic       rdy;
    logic       err;
    logic [7:0] cd;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_vec;
  int   n_err;
  int   tn;
  logic done;
  logic mis;

  freq_div_ctrl #(.WIDTH(8), .DEFAULT_DIV(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .div_in    (div_in),
    .div_valid (div_valid),
    .div_ready (div_ready),
    .div_err   (div_err),
    .div_out   (div_out),
    .tick      (tick),
    .cur_div   (cur_div),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cyc(input logic r, input logic en_i, input logic v, input logic [7:0] d,
                     input logic x_dout, input logic x_tick, input logic x_busy,
                     input logic x_rdy, input logic x_err, input logic [7:0] x_cd);
    exp_t x;
    rst       = r;
    en        = en_i;
    div_valid = v;
    div_in    = d;
    @(posedge clk);
    #1;
    x.tid  = tn;
    x.dout = x_dout;
    x.tick = x_tick;
    x.busy = x_busy;
    x.rdy  = x_rdy;
    x.err  = x_err;
    x.cd   = x_cd;
    sb.push_back(x);
  endtask

  task automatic run(input logic en_i, input logic v, input logic [7:0] d, input int k,
                     input int hi, input logic rdy, input logic err, input logic [7:0] cd);
    cyc(1'b1, en_i, v, d, (k < hi), (k == 0), 1'b1, rdy, err, cd);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_vec++;
      mis = 1'b0;
      if (div_out !== e.dout) mis = 1'b1;
      if (tick !== e.tick) mis = 1'b1;
      if (busy !== e.busy) mis = 1'b1;
      if (div_ready !== e.rdy) mis = 1'b1;
      if (div_err !== e.err) mis = 1'b1;
      if (cur_div !== e.cd) mis = 1'b1;
      if (mis) begin
        n_err++;
        $display("FAIL test%0d vec%0d: got dout=%b tick=%b busy=%b rdy=%b err=%b cur_div=%0d, expected dout=%b tick=%b busy=%b rdy=%b err=%b cur_div=%0d",
                 e.tid, n_vec, div_out, tick, busy, div_ready, div_err, cur_div,
                 e.dout, e.tick, e.busy, e.rdy, e.err, e.cd);
      end
    end else if (done) begin
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      if (n_err != 0 || n_vec == 0) $display("FAIL");
      else                          $display("PASS");
      $finish;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, vectors=%0d", n_vec);
    $fatal(1);
  end

  initial begin
    n_vec = 0; n_err = 0; done = 1'b0; tn = 0;
    rst = 1'b0; en = 1'b0; div_valid = 1'b0; div_in = 8'd0;

    tn = 1;
    cyc(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd5);
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < 5; k++) run(1'b1, 1'b0, 8'd0, k, 3, 1'b1, 1'b0, 8'd5);

    tn = 2;
    cyc(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd5);
    cyc(1'b1, 1'b0, 1'b1, 8'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd4);
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < 4; k++) run(1'b1, 1'b0, 8'd0, k, 2, 1'b1, 1'b0, 8'd4);

    tn = 3;
    run(1'b1, 1'b1, 8'd5, 0, 2, 1'b0, 1'b0, 8'd4);
    for (int k = 1; k < 4; k++) run(1'b1, 1'b0, 8'd0, k, 2, 1'b0, 1'b0, 8'd4);
    run(1'b1, 1'b0, 8'd0, 0, 3, 1'b1, 1'b0, 8'd5);
    run(1'b1, 1'b0, 8'd0, 1, 3, 1'b1, 1'b0, 8'd5);
    run(1'b1, 1'b1, 8'd8, 2, 3, 1'b0, 1'b0, 8'd5);
    run(1'b1, 1'b0, 8'd0, 3, 3, 1'b0, 1'b0, 8'd5);
    run(1'b1, 1'b0, 8'd0, 4, 3, 1'b0, 1'b0, 8'd5);
    run(1'b1, 1'b0, 8'd0, 0, 4, 1'b1, 1'b0, 8'd8);
    run(1'b1, 1'b0, 8'd0, 1, 4, 1'b1, 1'b0, 8'd8);

    tn = 4;
    run(1'b1, 1'b1, 8'd1, 2, 4, 1'b1, 1'b1, 8'd8);
    run(1'b1, 1'b0, 8'd0, 3, 4, 1'b1, 1'b0, 8'd8);
    run(1'b1, 1'b1, 8'd0, 4, 4, 1'b1, 1'b1, 8'd8);
    run(1'b1, 1'b0, 8'd0, 5, 4, 1'b1, 1'b0, 8'd8);
    run(1'b1, 1'b0, 8'd0, 6, 4, 1'b1, 1'b0, 8'd8);
    run(1'b1, 1'b1, 8'd6, 7, 4, 1'b0, 1'b0, 8'd8);

    tn = 5;
    run(1'b1, 1'b0, 8'd0, 0, 3, 1'b1, 1'b0, 8'd6);
    run(1'b1, 1'b0, 8'd0, 1, 3, 1'b1, 1'b0, 8'd6);
    run(1'b0, 1'b1, 8'd3, 2, 3, 1'b0, 1'b0, 8'd6);
    for (int k = 3; k < 6; k++) run(1'b0, 1'b0, 8'd0, k, 3, 1'b0, 1'b0, 8'd6);
    cyc(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd3);
    cyc(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd3);

    tn = 6;
    cyc(1'b1, 1'b0, 1'b1, 8'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd7);
    run(1'b1, 1'b0, 8'd0, 0, 4, 1'b1, 1'b0, 8'd7);
    run(1'b1, 1'b1, 8'd2, 1, 4, 1'b0, 1'b0, 8'd7);
    run(1'b1, 1'b0, 8'd0, 2, 4, 1'b0, 1'b0, 8'd7);
    run(1'b1, 1'b0, 8'd0, 3, 4, 1'b0, 1'b0, 8'd7);
    cyc(1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd5);
    cyc(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd5);
    run(1'b1, 1'b0, 8'd0, 0, 3, 1'b1, 1'b0, 8'd5);
    run(1'b0, 1'b0, 8'd0, 1, 3, 1'b1, 1'b0, 8'd5);
    for (int k = 2; k < 5; k++) run(1'b1, 1'b0, 8'd0, k, 3, 1'b1, 1'b0, 8'd5);
    run(1'b1, 1'b0, 8'd0, 0, 3, 1'b1, 1'b0, 8'd5);

    done = 1'b1;
  end

endmodule
